// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file write sequencer: parameter defaults,
// FSM state encoding and modulo-NREGS address stepping.
package reg_file_pkg;

    localparam int DW_DEF    = 16;
    localparam int NREGS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_e;

    function automatic int wrap_inc(input int addr, input int nregs);
        return (addr + 1 >= nregs) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/reg_file_wr_seq.sv
// Burst write initiator for the flattened register file: one command, count data
// words, one registered write per word. Optional abort input: REG_FILE_WR_SEQ_ABORT_EN.
module reg_file_wr_seq
    import reg_file_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = 1
) (
    input  logic          reset,
    input  logic          clock,
`ifdef REG_FILE_WR_SEQ_ABORT_EN
    input  logic          abort,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_count,
    input  logic          data_valid,
    output logic          data_ready,
    input  logic [DW-1:0] data_in,
    output logic          r_d_wen_out,
    output logic [AW-1:0] r_d_waddr_out,
    output logic [DW-1:0] d_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remain_q;
    logic          cmd_ready_q;
    logic          data_ready_q;
    logic          wen_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] d_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          abort_w;
    logic          cmd_legal_d;
    logic          data_acc_d;
    logic [AW-1:0] addr_d;

`ifdef REG_FILE_WR_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // data_ready drops combinationally on abort so nothing is accepted that cycle
    assign data_ready  = data_ready_q & ~abort_w;
    assign data_acc_d  = data_valid & data_ready;
    assign cmd_legal_d = (cmd_count != '0)
                      && (cmd_count <= (AW+1)'(NREGS))
                      && ({1'b0, cmd_base} < (AW+1)'(NREGS));
    assign addr_d      = AW'(wrap_inc(32'(addr_q), NREGS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            cmd_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            d_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_legal_d) begin
                            state_q      <= LOAD;
                            cmd_ready_q  <= 1'b0;
                            data_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            addr_q       <= cmd_base;
                            remain_q     <= cmd_count;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort_w) begin
                        state_q      <= IDLE;
                        data_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        err_q        <= 1'b1;
                    end else if (data_acc_d) begin
                        wen_q    <= 1'b1;
                        waddr_q  <= addr_q;
                        d_q      <= data_in;
                        addr_q   <= addr_d;
                        remain_q <= remain_q - (AW+1)'(1);
                        if (remain_q == (AW+1)'(1)) begin
                            state_q      <= FINISH;
                            data_ready_q <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    if (abort_w) begin
                        err_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign r_d_wen_out   = wen_q;
    assign r_d_waddr_out = waddr_q;
    assign d_out         = d_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
